ysyx_22041207_pipe_stage: RTL

//  Generic elastic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM...) that replaces hand-written per-signal stage regs.

---
 rtl/ysyx_22041207_pipe_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ysyx_22041207_pipe_stage.sv
// Elastic inter-stage pipeline register: DEPTH-entry FIFO holding WIDTH-bit payloads.
// Latency: 1 cycle. A push into an empty stage appears at the outputs on the next cycle.
// Backpressure: in_ready_o depends only on registered occupancy, rst, flush and hold.
//               It has no combinational path from out_ready_i.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   flush_i               drop all buffered entries and any push offered this cycle
//   hold_i                freeze the stage: no push, no pop; head stays visible
//   in_valid_i/_ready_o   upstream handshake carrying in_data_i
//   out_valid_o/_ready_i  downstream handshake carrying out_data_o (the head entry)
//   occupancy_o           number of entries currently stored
//   stall_cnt_o           cycles upstream offered data but was blocked (saturating)
//   bubble_cnt_o          cycles downstream was ready but the stage was empty (saturating)
// The perf counters exist only when YSYX_22041207_PIPE_PERF_EN is defined.
// Otherwise both counter outputs are tied to 0 and no counter flops are built.
module ysyx_22041207_pipe_stage #(
   parameter int WIDTH      = 64,
   parameter int DEPTH      = 2,
   parameter int ZERO_EMPTY = 1,
   parameter int CNT_W      = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         hold_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic [CNT_W-1:0]             stall_cnt_o,
   output logic [CNT_W-1:0]             bubble_cnt_o
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   // Payload storage is deliberately left unreset.
   // Only the pointers and the occupancy count define which entries are live.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             push, pop;

   // Explicit wrap at DEPTH-1, so non-power-of-2 depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign in_ready_o  = ~rst_i & ~flush_i & ~hold_i & (occ_q < OCC_FULL);
   assign out_valid_o = (occ_q != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i & ~hold_i & ~flush_i;

   // When empty, out_data_o shows a zero word (a NOP bubble) if ZERO_EMPTY is set.
   // This hides stale storage contents from the next stage.
   assign out_data_o  = ((ZERO_EMPTY != 0) && !out_valid_o) ? '0 : mem_q[rd_ptr_q];
   assign occupancy_o = occ_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         occ_d    = '0;
      end else begin
         // hold_i already suppresses push/pop, so a held stage falls through unchanged.
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop)      occ_d = occ_q + 1'b1;
         else if (pop && !push) occ_d = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

`ifdef YSYX_22041207_PIPE_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;
   logic             stall_inc;
   logic             bubble_inc;

   // Reset is handled by the register's reset branch, so it is left out of these terms.
   assign stall_inc  = in_valid_i & ~in_ready_o;
   assign bubble_inc = ~out_valid_o & out_ready_i & ~hold_i;

   // Only rst clears the counters; flush must not disturb the statistics.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         if (stall_inc && (stall_q != '1))   stall_q  <= stall_q + 1'b1;
         if (bubble_inc && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
      end
   end

   assign stall_cnt_o  = stall_q;
   assign bubble_cnt_o = bubble_q;
`else
   assign stall_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule
